// File: rtl/spectrum_pkg.sv
// Constants, state encoding and sample conversion shared by the FFT input
// streamer and the power/display path.
package spectrum_pkg;

  localparam int FRAME_LEN = 1024;
  localparam int ADC_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_STREAM = 2'd2,
    ST_GAP    = 2'd3
  } stream_state_t;

  // Removing the mid-scale offset from an offset-binary code is an MSB flip.
  function automatic logic signed [ADC_W-1:0] offset_to_signed(input logic [ADC_W-1:0] sample);
    return {~sample[ADC_W-1], sample[ADC_W-2:0]};
  endfunction

endpackage

// File: rtl/adc_frame_streamer_if.sv
// AXI4-Stream beat bundle (data, valid, last, ready) between the frame
// streamer and the FFT core.
interface adc_frame_streamer_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry register skid buffer. The head register drives the stream output
// directly so valid/data never depend combinationally on ready.
module axis_skid_buffer #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic [1:0]       occupancy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] tail_reg;
  logic [1:0]       occ_reg;
  logic             pop;

  assign out_valid = (occ_reg != 2'd0);
  assign out_data  = head_reg;
  assign occupancy = occ_reg;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_reg == 2'd0) begin
            head_reg <= push_data;
            occ_reg  <= 2'd1;
          end else if (occ_reg == 2'd1) begin
            tail_reg <= push_data;
            occ_reg  <= 2'd2;
          end
        end
        2'b01: begin
          // Head only advances when a second entry exists, so an idle
          // output keeps presenting the last beat's data.
          if (occ_reg == 2'd2) begin
            head_reg <= tail_reg;
          end
          occ_reg <= occ_reg - 2'd1;
        end
        2'b11: begin
          if (occ_reg == 2'd2) begin
            head_reg <= tail_reg;
            tail_reg <= push_data;
          end else begin
            head_reg <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/adc_frame_streamer.sv
// Drains offset-binary ADC samples from the sample FIFO and streams them as
// signed fixed-length frames with tlast, followed by a paced idle gap.
module adc_frame_streamer #(
  parameter int FRAME_LEN  = spectrum_pkg::FRAME_LEN,
  parameter int ADC_W      = spectrum_pkg::ADC_W,
  parameter int DATA_W     = 16,
  parameter int GAP_CYCLES = 24000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [ADC_W-1:0]     fifo_rd_data,
  input  logic                 fifo_rd_empty,
  input  logic                 fifo_almost_full,
  output logic                 fifo_rd_en,
  adc_frame_streamer_if.master m_axis,
  output logic                 frame_done,
  output logic                 busy,
  output logic [15:0]          underrun_cnt
);

  import spectrum_pkg::*;

  localparam int CNT_W = $clog2(FRAME_LEN) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  stream_state_t state_reg;
  stream_state_t state_next;

  logic [CNT_W-1:0] rd_cnt_reg;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             inflight_reg;
  logic             inflight_last_reg;
  logic [15:0]      underrun_reg;

  logic                     pop;
  logic                     last_hs;
  logic                     rd_last;
  logic                     rd_allowed;
  logic [2:0]               slots_used;
  logic [1:0]               skid_occ;
  logic signed [ADC_W-1:0]  sample_signed;
  logic [DATA_W-1:0]        sample_ext;
  logic [DATA_W:0]          skid_out;

  assign sample_signed = offset_to_signed(fifo_rd_data);
  assign sample_ext    = DATA_W'(sample_signed);

  axis_skid_buffer #(
    .WIDTH(DATA_W + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data ({inflight_last_reg, sample_ext}),
    .occupancy (skid_occ),
    .out_valid (m_axis.tvalid),
    .out_data  (skid_out),
    .out_ready (m_axis.tready)
  );

  assign m_axis.tlast = skid_out[DATA_W];
  assign m_axis.tdata = skid_out[DATA_W-1:0];

  assign pop     = m_axis.tvalid & m_axis.tready;
  assign last_hs = pop & (beat_cnt_reg == CNT_W'(FRAME_LEN - 1));
  assign rd_last = (rd_cnt_reg == CNT_W'(FRAME_LEN - 1));

  // A beat leaving this cycle frees its slot, which keeps one read issued
  // per cycle while the sink accepts every beat.
  assign slots_used = {1'b0, skid_occ} + {2'b00, inflight_reg} - {2'b00, pop};
  assign rd_allowed = !fifo_rd_empty
                    && (rd_cnt_reg < CNT_W'(FRAME_LEN))
                    && (slots_used < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fifo_rd_en = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_ARM;
        end
      end
      ST_ARM: begin
        if (fifo_almost_full) begin
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        fifo_rd_en = rd_allowed;
        if (last_hs) begin
          frame_done = 1'b1;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
          state_next = enable ? ST_ARM : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_reg   <= '0;
      beat_cnt_reg <= '0;
    end else if (state_next == ST_ARM) begin
      rd_cnt_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
      end
      if (pop) begin
        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
      end
    end
  end

  // The FIFO returns data one cycle after the strobe; tag it with its
  // frame position so tlast travels with the sample through the skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      inflight_reg      <= fifo_rd_en;
      inflight_last_reg <= fifo_rd_en & rd_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_reg <= '0;
    end else if (state_reg == ST_GAP) begin
      gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
    end else begin
      gap_cnt_reg <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_reg <= '0;
    end else if ((state_reg == ST_STREAM) && (skid_occ == 2'd0) && fifo_rd_empty
                 && (underrun_reg != 16'hFFFF)) begin
      underrun_reg <= underrun_reg + 16'd1;
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign underrun_cnt = underrun_reg;

endmodule

// File: tb/tb_adc_frame_streamer.sv
// Directed bench for adc_frame_streamer: FIFO model, AXI monitor, table-driven
// frame checks plus hand-written stall, starvation, enable and reset sequences.
module tb_adc_frame_streamer;

  localparam int FL  = 16;
  localparam int GAP = 20;
  localparam int AW  = 8;
  localparam int DW  = 16;

  typedef struct {
    logic [7:0]  sample;
    logic [15:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t tbl [FL];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty = 1'b1;
  logic          fifo_almost_full = 1'b0;
  logic          fifo_rd_en;
  logic          frame_done;
  logic          busy;
  logic [15:0]   underrun_cnt;

  adc_frame_streamer_if #(.DATA_W(DW)) m_axis ();

  adc_frame_streamer #(
    .FRAME_LEN  (FL),
    .ADC_W      (AW),
    .DATA_W     (DW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_rd_empty    (fifo_rd_empty),
    .fifo_almost_full (fifo_almost_full),
    .fifo_rd_en       (fifo_rd_en),
    .m_axis           (m_axis),
    .frame_done       (frame_done),
    .busy             (busy),
    .underrun_cnt     (underrun_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: one-cycle read latency, flags change only on the clock edge
  logic [7:0] fifo_mem [0:4095];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  bit  hold = 1'b0;
  bit  flush = 1'b0;
  bit  pop_pend = 1'b0;
  int  n_underflow = 0;
  int  rp;

  always @(posedge clk) begin
    rp = rd_ptr;
    if (flush) begin
      rp = wr_ptr;
    end else if (pop_pend) begin
      if (rp != wr_ptr) begin
        fifo_rd_data <= fifo_mem[rp];
        rp = rp + 1;
      end else begin
        n_underflow++;
      end
    end
    rd_ptr           <= rp;
    fifo_rd_empty    <= hold || (rp == wr_ptr);
    fifo_almost_full <= ((wr_ptr - rp) >= FL);
  end

  // Monitor on the falling edge
  logic [15:0] cap_d [$];
  bit          cap_l [$];
  int          hs_cyc [$];
  int          rd_cyc [$];
  int          done_cyc [$];
  bit          stall_pend = 1'b0;
  logic [15:0] held_d = '0;
  logic        held_l = 1'b0;
  int          n_unstable = 0;
  int          n_done_mis = 0;

  always @(negedge clk) begin
    pop_pend = fifo_rd_en;
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (fifo_rd_en) rd_cyc.push_back(cyc);
      if (stall_pend && (!m_axis.tvalid || m_axis.tdata != held_d || m_axis.tlast != held_l))
        n_unstable++;
      if (m_axis.tvalid && m_axis.tready) begin
        cap_d.push_back(m_axis.tdata);
        cap_l.push_back(m_axis.tlast);
        hs_cyc.push_back(cyc);
      end
      if (frame_done) done_cyc.push_back(cyc);
      if (frame_done != (m_axis.tvalid && m_axis.tready && m_axis.tlast)) n_done_mis++;
      stall_pend = m_axis.tvalid && !m_axis.tready;
      held_d     = m_axis.tdata;
      held_l     = m_axis.tlast;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, got);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_tests++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
    end else begin
      $display("[TB] ok   %s = %0d", name, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return hs_cyc.size();
      1:       return rd_cyc.size();
      default: return done_cyc.size();
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int target,
                          input int budget, input bit rnd);
    int k = 0;
    while (qsize(which) < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
      if (rnd) m_axis.tready = ($urandom_range(0, 99) < 30);
    end
    if (qsize(which) < target) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s timeout: got %0d events, required %0d", name, qsize(which), target);
    end
  endtask

  function automatic logic [7:0] ramp(input int i, input int seed);
    return 8'(i * 13 + seed);
  endfunction

  function automatic logic [15:0] exp_of(input logic [7:0] b);
    return 16'(int'(b) - 128);
  endfunction

  task automatic load_tbl();
    for (int i = 0; i < FL; i++) begin
      fifo_mem[wr_ptr] = tbl[i].sample;
      wr_ptr++;
    end
  endtask

  task automatic load_ramp(input int seed);
    for (int i = 0; i < FL; i++) begin
      fifo_mem[wr_ptr] = ramp(i, seed);
      wr_ptr++;
    end
  endtask

  task automatic check_frame(input string tag, input int base, input bit use_tbl, input int seed);
    logic [15:0] ed;
    logic        el;
    for (int i = 0; i < FL; i++) begin
      ed = use_tbl ? tbl[i].exp_data : exp_of(ramp(i, seed));
      el = use_tbl ? tbl[i].exp_last : (i == FL - 1);
      if (base + i < cap_d.size()) begin
        check($sformatf("%s_beat%0d_data", tag, i), {16'h0, cap_d[base + i]}, {16'h0, ed});
        check($sformatf("%s_beat%0d_last", tag, i), {31'h0, cap_l[base + i]}, {31'h0, el});
      end else begin
        check($sformatf("%s_beat%0d_missing", tag, i), 32'(cap_d.size()), 32'(base + i + 1));
      end
    end
  endtask

  int b_hs, b_rd, b_done, en_cyc;

  initial begin
    tbl[0]  = '{8'h00, 16'hFF80, 1'b0};
    tbl[1]  = '{8'h01, 16'hFF81, 1'b0};
    tbl[2]  = '{8'h7F, 16'hFFFF, 1'b0};
    tbl[3]  = '{8'h80, 16'h0000, 1'b0};
    tbl[4]  = '{8'h81, 16'h0001, 1'b0};
    tbl[5]  = '{8'hFF, 16'h007F, 1'b0};
    tbl[6]  = '{8'h40, 16'hFFC0, 1'b0};
    tbl[7]  = '{8'hC0, 16'h0040, 1'b0};
    tbl[8]  = '{8'h10, 16'hFF90, 1'b0};
    tbl[9]  = '{8'hF0, 16'h0070, 1'b0};
    tbl[10] = '{8'h55, 16'hFFD5, 1'b0};
    tbl[11] = '{8'hAA, 16'h002A, 1'b0};
    tbl[12] = '{8'h3C, 16'hFFBC, 1'b0};
    tbl[13] = '{8'hC3, 16'h0043, 1'b0};
    tbl[14] = '{8'h7E, 16'hFFFE, 1'b0};
    tbl[15] = '{8'hFE, 16'h007E, 1'b1};
    m_axis.tready = 1'b1;

    // Reset state
    tick(3);
    check("rst_fifo_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    check("rst_tvalid", {31'h0, m_axis.tvalid}, 32'h0);
    check("rst_tlast", {31'h0, m_axis.tlast}, 32'h0);
    check("rst_tdata", {16'h0, m_axis.tdata}, 32'h0);
    check("rst_frame_done", {31'h0, frame_done}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_underrun", {16'h0, underrun_cnt}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Table frame with tready=1: conversion, latency, throughput
    load_tbl();
    tick(2);
    b_hs = hs_cyc.size(); b_rd = rd_cyc.size(); b_done = done_cyc.size();
    en_cyc = cyc;
    enable = 1'b1;
    wait_for("frame1_done", 2, b_done + 1, 200, 1'b0);
    check("f1_start_latency", 32'(rd_cyc[b_rd] - en_cyc), 32'd2);
    check("f1_first_beat_latency", 32'(hs_cyc[b_hs] - rd_cyc[b_rd]), 32'd2);
    check("f1_read_to_last_beat", 32'(hs_cyc[b_hs + FL - 1] - rd_cyc[b_rd]), 32'(FL + 1));
    check("f1_done_on_last_beat", 32'(done_cyc[b_done]), 32'(hs_cyc[b_hs + FL - 1]));
    check("f1_reads", 32'(rd_cyc.size() - b_rd), 32'(FL));
    check_frame("f1", b_hs, 1'b1, 0);

    // Same table with 30% random tready; gap measured to next frame's first read
    load_tbl();
    b_hs = hs_cyc.size(); b_rd = rd_cyc.size();
    wait_for("frame2_done", 2, b_done + 2, 3000, 1'b1);
    enable = 1'b0;
    m_axis.tready = 1'b1;
    check("f2_gap_to_next_read", 32'(rd_cyc[b_rd] - done_cyc[b_done]), 32'(GAP + 2));
    check("f2_reads", 32'(rd_cyc.size() - b_rd), 32'(FL));
    check("f2_one_done", 32'(done_cyc.size() - b_done), 32'd2);
    check_frame("f2", b_hs, 1'b1, 0);
    tick(GAP + 5);
    check("f2_idle_busy", {31'h0, busy}, 32'h0);

    // Starvation: FIFO held empty for 37 cycles mid-frame
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    load_ramp(5);
    tick(2);
    b_hs = hs_cyc.size(); b_rd = rd_cyc.size(); b_done = done_cyc.size();
    enable = 1'b1;
    wait_for("f3_reads8", 1, b_rd + 8, 100, 1'b0);
    hold = 1'b1;
    tick(37);
    hold = 1'b0;
    wait_for("f3_done", 2, b_done + 1, 300, 1'b0);
    check_range("f3_underrun_cnt", int'(underrun_cnt), 35, 39);
    check("f3_reads", 32'(rd_cyc.size() - b_rd), 32'(FL));
    check_frame("f3", b_hs, 1'b0, 5);

    // enable dropped mid-frame: frame completes, then back to IDLE
    load_ramp(77);
    b_hs = hs_cyc.size(); b_rd = rd_cyc.size(); b_done = done_cyc.size();
    wait_for("f4_beat5", 0, b_hs + 5, GAP + 100, 1'b0);
    enable = 1'b0;
    wait_for("f4_done", 2, b_done + 1, 200, 1'b0);
    check_frame("f4", b_hs, 1'b0, 77);
    load_ramp(200);
    tick(GAP + 30);
    check("f4_idle_busy", {31'h0, busy}, 32'h0);
    check("f4_no_more_reads", 32'(rd_cyc.size() - b_rd), 32'(FL));

    // Asynchronous reset mid-frame, then a clean frame from beat 0
    b_hs = hs_cyc.size();
    enable = 1'b1;
    wait_for("f5_beat8", 0, b_hs + 8, 100, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_fifo_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    check("arst_tvalid", {31'h0, m_axis.tvalid}, 32'h0);
    check("arst_tlast", {31'h0, m_axis.tlast}, 32'h0);
    check("arst_tdata", {16'h0, m_axis.tdata}, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_underrun", {16'h0, underrun_cnt}, 32'h0);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    load_ramp(31);
    tick(2);
    b_hs = hs_cyc.size(); b_done = done_cyc.size();
    rst_n = 1'b1;
    wait_for("f5_done", 2, b_done + 1, 200, 1'b0);
    check_frame("f5", b_hs, 1'b0, 31);

    // tready low for 100 cycles with a full FIFO
    m_axis.tready = 1'b0;
    load_ramp(99);
    b_hs = hs_cyc.size(); b_rd = rd_cyc.size(); b_done = done_cyc.size();
    wait_for("f6_first_read", 1, b_rd + 1, GAP + 50, 1'b0);
    tick(100);
    check("f6_reads_while_stalled", 32'(rd_cyc.size() - b_rd), 32'd2);
    check("f6_no_beats_while_stalled", 32'(hs_cyc.size() - b_hs), 32'd0);
    check("f6_tvalid_held", {31'h0, m_axis.tvalid}, 32'h1);
    m_axis.tready = 1'b1;
    wait_for("f6_done", 2, b_done + 1, 200, 1'b0);
    check("f6_reads", 32'(rd_cyc.size() - b_rd), 32'(FL));
    check_frame("f6", b_hs, 1'b0, 99);

    // Whole-run invariants
    check("stall_stability_violations", 32'(n_unstable), 32'd0);
    check("fifo_underflow_reads", 32'(n_underflow), 32'd0);
    check("frame_done_vs_last_hs", 32'(n_done_mis), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
